regbank_param: RTL and testbench

//   Parametrised register bank: NREG registers of WIDTH bits, each with an access mode set at

---
 rtl/regbank_param.sv | 154 +++++++++++++++
 tb/tb_regbank_param.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/regbank_param.sv
// Parametrised register bank with per-register access modes behind a valid/ready
// request port and a single-slot, back-pressurable response register.
module regbank_param #(
   parameter int                    WIDTH    = 16,
   parameter int                    NREG     = 12,
   parameter int                    AW       = 4,
   parameter logic [3*NREG-1:0]     MODES    = '0,
   parameter logic [WIDTH*NREG-1:0] RST_VALS = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [AW-1:0]         req_addr,
   input  logic [WIDTH-1:0]      req_wdata,
   input  logic [WIDTH-1:0]      req_wmask,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [WIDTH-1:0]      rsp_rdata,
   output logic                  rsp_err,
   input  logic [NREG-1:0]       ext_we,
   input  logic [NREG*WIDTH-1:0] ext_data,
   input  logic [NREG*WIDTH-1:0] ro_data,
   output logic [NREG*WIDTH-1:0] q,
   output logic [NREG-1:0]       wr_pulse,
   output logic [NREG-1:0]       rd_pulse
);

   localparam logic [2:0] M_NONE = 3'd0;
   localparam logic [2:0] M_RO   = 3'd1;
   localparam logic [2:0] M_RW   = 3'd2;
   localparam logic [2:0] M_RWE  = 3'd3;
   localparam logic [2:0] M_WO   = 3'd4;
   localparam logic [2:0] M_W1C  = 3'd5;
   localparam logic [2:0] M_RC   = 3'd6;

   logic                        rsp_valid_reg;
   logic [WIDTH-1:0]            rsp_rdata_reg, rsp_rdata_next;
   logic                        rsp_err_reg, rsp_err_next;
   logic [NREG-1:0]             wr_pulse_reg, rd_pulse_reg;
   logic                        accept;
   logic [NREG-1:0]             hit, bus_wr, bus_rd, reg_err;
   logic [NREG-1:0][WIDTH-1:0]  rd_val;
   logic [WIDTH-1:0]            wr_bits;
   logic                        unused_inputs;

   assign req_ready = !rsp_valid_reg || rsp_ready;
   assign accept    = req_valid && req_ready;
   assign wr_bits   = req_wdata & req_wmask;

   // Not every slot consumes its ro_data/ext_* slice; fold them into a sink.
   assign unused_inputs = ^{ro_data, ext_data, ext_we};

   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
         localparam logic [2:0] MODE = MODES[3*gi +: 3];
         logic [WIDTH-1:0] val_reg, val_next;
         logic [WIDTH-1:0] ext_slice;

         assign ext_slice   = ext_data[WIDTH*gi +: WIDTH];
         assign hit[gi]     = accept && (req_addr == AW'(gi));
         assign reg_err[gi] = (MODE == M_NONE) || (MODE > M_RC) ||
                              ((MODE == M_RO) && req_write);
         assign bus_wr[gi]  = hit[gi] && req_write && !reg_err[gi];
         assign bus_rd[gi]  = hit[gi] && !req_write && !reg_err[gi];

         always_comb begin
            val_next = val_reg;
            case (MODE)
               M_RW, M_WO: begin
                  if (bus_wr[gi])
                     val_next = (val_reg & ~req_wmask) | wr_bits;
               end
               M_RWE: begin
                  if (ext_we[gi])
                     val_next = ext_slice;
                  else if (bus_wr[gi])
                     val_next = (val_reg & ~req_wmask) | wr_bits;
               end
               // Set is OR'd in after the clear so hardware sets always win.
               M_W1C: begin
                  val_next = (val_reg & ~(bus_wr[gi] ? wr_bits : '0)) |
                             (ext_we[gi] ? ext_slice : '0);
               end
               M_RC: begin
                  val_next = (bus_rd[gi] ? '0 : val_reg) |
                             (ext_we[gi] ? ext_slice : '0);
               end
               default: ;
            endcase
         end

         always_ff @(posedge clk) begin
            if (rst)
               val_reg <= RST_VALS[WIDTH*gi +: WIDTH];
            else
               val_reg <= val_next;
         end

         always_comb begin
            rd_val[gi] = '0;
            case (MODE)
               M_RO:                  rd_val[gi] = ro_data[WIDTH*gi +: WIDTH];
               M_RW, M_RWE, M_W1C,
               M_RC:                  rd_val[gi] = val_reg;
               default:               rd_val[gi] = '0;
            endcase
         end

         assign q[WIDTH*gi +: WIDTH] =
            ((MODE == M_NONE) || (MODE == M_RO) || (MODE > M_RC)) ? '0 : val_reg;
      end
   endgenerate

   // Out-of-range addresses match no slot and therefore keep the error default.
   always_comb begin
      rsp_rdata_next = '0;
      rsp_err_next   = 1'b1;
      for (int i = 0; i < NREG; i++) begin
         if (req_addr == AW'(i)) begin
            rsp_err_next   = reg_err[i];
            rsp_rdata_next = (req_write || reg_err[i]) ? '0 : rd_val[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_reg <= 1'b0;
         rsp_rdata_reg <= '0;
         rsp_err_reg   <= 1'b0;
         wr_pulse_reg  <= '0;
         rd_pulse_reg  <= '0;
      end else begin
         if (accept) begin
            rsp_valid_reg <= 1'b1;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
         end else if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
         end
         wr_pulse_reg <= bus_wr;
         rd_pulse_reg <= bus_rd;
      end
   end

   assign rsp_valid = rsp_valid_reg;
   assign rsp_rdata = rsp_rdata_reg;
   assign rsp_err   = rsp_err_reg;
   assign wr_pulse  = wr_pulse_reg;
   assign rd_pulse  = rd_pulse_reg;

endmodule

// File: tb/tb_regbank_param.sv
// Directed bench for regbank_param: reg0 RO, reg1-2 RW, reg3 RWE, reg4 WO,
// reg5 W1C, reg6 RC, reg7 NONE, reg8-11 RW.
module tb_regbank_param;

   localparam int W = 16;
   localparam int N = 12;
   localparam int A = 4;
   localparam logic [3*N-1:0] MODES = {3'd2, 3'd2, 3'd2, 3'd2, 3'd0, 3'd6,
                                       3'd5, 3'd4, 3'd3, 3'd2, 3'd2, 3'd1};
   localparam logic [W*N-1:0] RSTV = {{(W*N-48){1'b0}}, 16'h00A5, 16'h1234, 16'h0000};

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           req_valid = 1'b0;
   logic           req_ready;
   logic           req_write = 1'b0;
   logic [A-1:0]   req_addr = '0;
   logic [W-1:0]   req_wdata = '0;
   logic [W-1:0]   req_wmask = '0;
   logic           rsp_valid;
   logic           rsp_ready = 1'b1;
   logic [W-1:0]   rsp_rdata;
   logic           rsp_err;
   logic [N-1:0]   ext_we = '0;
   logic [N*W-1:0] ext_data = '0;
   logic [N*W-1:0] ro_data = '0;
   logic [N*W-1:0] q;
   logic [N-1:0]   wr_pulse;
   logic [N-1:0]   rd_pulse;

   int vectors = 0;
   int miscompares = 0;

   regbank_param #(
      .WIDTH(W), .NREG(N), .AW(A), .MODES(MODES), .RST_VALS(RSTV)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .ext_we(ext_we), .ext_data(ext_data), .ro_data(ro_data),
      .q(q), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One-cycle request; caller guarantees req_ready is high.
   task automatic issue(input logic wr, input logic [A-1:0] addr,
                        input logic [W-1:0] wd, input logic [W-1:0] wm);
      req_valid = 1'b1; req_write = wr; req_addr = addr;
      req_wdata = wd;   req_wmask = wm;
      step();
      req_valid = 1'b0;
      $display("txn %s addr=%0d wdata=%h wmask=%h -> rdata=%h err=%b",
               wr ? "WR" : "RD", addr, wd, wm, rsp_rdata, rsp_err);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      vectors++; if (q[2*W +: W] !== 16'h00A5) begin miscompares++; $display("FAIL reset_q2 got %h exp 00a5", q[2*W +: W]); end
      vectors++; if (q[1*W +: W] !== 16'h1234) begin miscompares++; $display("FAIL reset_q1 got %h exp 1234", q[1*W +: W]); end
      vectors++; if (q[0 +: W] !== 16'h0000) begin miscompares++; $display("FAIL reset_q0_ro got %h exp 0000", q[0 +: W]); end
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
      vectors++; if ((wr_pulse | rd_pulse) !== 12'h000) begin miscompares++; $display("FAIL reset_pulses got %h exp 000", wr_pulse | rd_pulse); end
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
   endtask

   task automatic test_rw_masked();
      issue(1'b1, 4'd2, 16'hFFFF, 16'h0F00);
      vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL rw_wr_valid got %b exp 1", rsp_valid); end
      vectors++; if (rsp_rdata !== 16'h0000 || rsp_err !== 1'b0) begin miscompares++; $display("FAIL rw_wr_rsp got %h/%b exp 0000/0", rsp_rdata, rsp_err); end
      vectors++; if (q[2*W +: W] !== 16'h0FA5) begin miscompares++; $display("FAIL rw_wr_q2 got %h exp 0fa5", q[2*W +: W]); end
      vectors++; if (wr_pulse !== 12'h004) begin miscompares++; $display("FAIL rw_wr_pulse got %h exp 004", wr_pulse); end
      issue(1'b0, 4'd2, 16'h0000, 16'h0000);
      vectors++; if (rsp_rdata !== 16'h0FA5 || rsp_err !== 1'b0) begin miscompares++; $display("FAIL rw_rd_rsp got %h/%b exp 0fa5/0", rsp_rdata, rsp_err); end
      vectors++; if (rd_pulse !== 12'h004 || wr_pulse !== 12'h000) begin miscompares++; $display("FAIL rw_rd_pulses got rd %h wr %h exp 004/000", rd_pulse, wr_pulse); end
      step();
      vectors++; if (rd_pulse !== 12'h000 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rw_idle got rd %h valid %b exp 000/0", rd_pulse, rsp_valid); end
   endtask

   task automatic test_back_pressure();
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd1;
      step();
      vectors++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h1234) begin miscompares++; $display("FAIL bp_first got %b/%h exp 1/1234", rsp_valid, rsp_rdata); end
      vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready_low got %b exp 0", req_ready); end
      vectors++; if (rd_pulse !== 12'h002) begin miscompares++; $display("FAIL bp_first_pulse got %h exp 002", rd_pulse); end
      req_addr = 4'd2;
      step(); step();
      vectors++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h1234) begin miscompares++; $display("FAIL bp_hold got %b/%h exp 1/1234", rsp_valid, rsp_rdata); end
      vectors++; if (rd_pulse !== 12'h000) begin miscompares++; $display("FAIL bp_stall_pulse got %h exp 000", rd_pulse); end
      rsp_ready = 1'b1;
      #1;
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_release got %b exp 1", req_ready); end
      step();
      vectors++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h0FA5) begin miscompares++; $display("FAIL bp_second got %b/%h exp 1/0fa5", rsp_valid, rsp_rdata); end
      req_addr = 4'd8;
      step();
      vectors++; if (rsp_rdata !== 16'h0000 || rsp_err !== 1'b0 || rd_pulse !== 12'h100) begin miscompares++; $display("FAIL bp_third got %h/%b/%h exp 0000/0/100", rsp_rdata, rsp_err, rd_pulse); end
      req_valid = 1'b0;
      step();
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain got %b exp 0", rsp_valid); end
      $display("txn back-pressure burst of 3 reads complete");
   endtask

   task automatic test_rwe_wo_ro();
      ext_we[3] = 1'b1; ext_data[3*W +: W] = 16'hAB00;
      issue(1'b1, 4'd3, 16'h00FF, 16'hFFFF);
      ext_we = '0;
      vectors++; if (q[3*W +: W] !== 16'hAB00 || rsp_err !== 1'b0) begin miscompares++; $display("FAIL rwe_ext_wins got %h/%b exp ab00/0", q[3*W +: W], rsp_err); end
      issue(1'b1, 4'd3, 16'h00FF, 16'h00F0);
      vectors++; if (q[3*W +: W] !== 16'hABF0) begin miscompares++; $display("FAIL rwe_masked got %h exp abf0", q[3*W +: W]); end
      issue(1'b1, 4'd4, 16'h5A5A, 16'hFFFF);
      vectors++; if (q[4*W +: W] !== 16'h5A5A) begin miscompares++; $display("FAIL wo_q got %h exp 5a5a", q[4*W +: W]); end
      issue(1'b0, 4'd4, 16'h0000, 16'h0000);
      vectors++; if (rsp_rdata !== 16'h0000 || rsp_err !== 1'b0 || rd_pulse !== 12'h010) begin miscompares++; $display("FAIL wo_read got %h/%b/%h exp 0000/0/010", rsp_rdata, rsp_err, rd_pulse); end
      issue(1'b0, 4'd0, 16'h0000, 16'h0000);
      vectors++; if (rsp_rdata !== 16'hBEEF || rsp_err !== 1'b0) begin miscompares++; $display("FAIL ro_read got %h/%b exp beef/0", rsp_rdata, rsp_err); end
   endtask

   task automatic test_w1c();
      ext_we[5] = 1'b1; ext_data[5*W +: W] = 16'h0003;
      issue(1'b1, 4'd5, 16'h0001, 16'hFFFF);
      ext_we = '0;
      vectors++; if (q[5*W +: W] !== 16'h0003) begin miscompares++; $display("FAIL w1c_set_wins got %h exp 0003", q[5*W +: W]); end
      issue(1'b1, 4'd5, 16'h0001, 16'hFFFF);
      vectors++; if (q[5*W +: W] !== 16'h0002) begin miscompares++; $display("FAIL w1c_clear got %h exp 0002", q[5*W +: W]); end
      issue(1'b0, 4'd5, 16'h0000, 16'h0000);
      vectors++; if (rsp_rdata !== 16'h0002) begin miscompares++; $display("FAIL w1c_read got %h exp 0002", rsp_rdata); end
   endtask

   task automatic test_rc();
      ext_we[6] = 1'b1; ext_data[6*W +: W] = 16'h0010;
      step();
      ext_we = '0;
      vectors++; if (q[6*W +: W] !== 16'h0010) begin miscompares++; $display("FAIL rc_set got %h exp 0010", q[6*W +: W]); end
      issue(1'b0, 4'd6, 16'h0000, 16'h0000);
      vectors++; if (rsp_rdata !== 16'h0010 || rd_pulse !== 12'h040 || q[6*W +: W] !== 16'h0000) begin miscompares++; $display("FAIL rc_read1 got %h/%h/%h exp 0010/040/0000", rsp_rdata, rd_pulse, q[6*W +: W]); end
      step();
      vectors++; if (rd_pulse !== 12'h000) begin miscompares++; $display("FAIL rc_pulse_len got %h exp 000", rd_pulse); end
      issue(1'b0, 4'd6, 16'h0000, 16'h0000);
      vectors++; if (rsp_rdata !== 16'h0000 || rd_pulse !== 12'h040) begin miscompares++; $display("FAIL rc_read2 got %h/%h exp 0000/040", rsp_rdata, rd_pulse); end
      issue(1'b1, 4'd6, 16'hFFFF, 16'hFFFF);
      vectors++; if (q[6*W +: W] !== 16'h0000 || rsp_err !== 1'b0) begin miscompares++; $display("FAIL rc_write_ignored got %h/%b exp 0000/0", q[6*W +: W], rsp_err); end
      ext_we[6] = 1'b1; ext_data[6*W +: W] = 16'h0010;
      step();
      ext_data[6*W +: W] = 16'h0004;
      issue(1'b0, 4'd6, 16'h0000, 16'h0000);
      ext_we = '0;
      vectors++; if (rsp_rdata !== 16'h0010 || q[6*W +: W] !== 16'h0004) begin miscompares++; $display("FAIL rc_set_survives got %h/%h exp 0010/0004", rsp_rdata, q[6*W +: W]); end
   endtask

   task automatic test_errors();
      issue(1'b0, 4'd12, 16'h0000, 16'h0000);
      vectors++; if (rsp_err !== 1'b1 || rsp_rdata !== 16'h0000 || rd_pulse !== 12'h000) begin miscompares++; $display("FAIL err_addr_nreg got %b/%h/%h exp 1/0000/000", rsp_err, rsp_rdata, rd_pulse); end
      issue(1'b1, 4'd0, 16'hFFFF, 16'hFFFF);
      vectors++; if (rsp_err !== 1'b1 || wr_pulse !== 12'h000 || q[0 +: W] !== 16'h0000) begin miscompares++; $display("FAIL err_write_ro got %b/%h/%h exp 1/000/0000", rsp_err, wr_pulse, q[0 +: W]); end
      issue(1'b0, 4'd7, 16'h0000, 16'h0000);
      vectors++; if (rsp_err !== 1'b1 || rsp_rdata !== 16'h0000) begin miscompares++; $display("FAIL err_none got %b/%h exp 1/0000", rsp_err, rsp_rdata); end
      issue(1'b1, 4'd15, 16'hFFFF, 16'hFFFF);
      vectors++; if (rsp_err !== 1'b1 || wr_pulse !== 12'h000) begin miscompares++; $display("FAIL err_addr15 got %b/%h exp 1/000", rsp_err, wr_pulse); end
      vectors++; if (q[2*W +: W] !== 16'h0FA5 || q[8*W +: W] !== 16'h0000) begin miscompares++; $display("FAIL err_q_unchanged got %h/%h exp 0fa5/0000", q[2*W +: W], q[8*W +: W]); end
   endtask

   task automatic test_reset_midflight();
      rsp_ready = 1'b0;
      issue(1'b0, 4'd2, 16'h0000, 16'h0000);
      vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL mid_pending got %b exp 1", rsp_valid); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      vectors++; if (rsp_valid !== 1'b0 || q[2*W +: W] !== 16'h00A5) begin miscompares++; $display("FAIL mid_reset got %b/%h exp 0/00a5", rsp_valid, q[2*W +: W]); end
      rsp_ready = 1'b1;
      step();
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL mid_no_rsp got %b exp 0", rsp_valid); end
   endtask

   initial begin
      ro_data[0 +: W] = 16'hBEEF;
      test_reset();
      test_rw_masked();
      test_back_pressure();
      test_rwe_wo_ro();
      test_w1c();
      test_rc();
      test_errors();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
